// File: rtl/qpsk_framer.sv
// ---------------------------------------------------------------------------
// qpsk_framer
// Builds a QPSK burst from a byte stream. Each frame is:
//   - PREAMBLE_SYMS preamble symbols, alternating 00, 11, 00, ...
//   - the 32-bit SYNC_WORD, sent MSB first as 16 dibits
//   - payload bytes, each sent MSB first as 4 dibits
// Every symbol lasts SPS clock cycles. A low i_ready freezes the framer.
//
// Ports
//   clk, rst_n       : rising-edge clock; asynchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready   : payload byte stream (valid/ready handshake)
//   i_ready          : downstream modulator ready; low stalls the framer
//   o_I, o_Q         : current dibit (o_I carries the MSB-side bit)
//   o_valid          : high while a frame is in progress
//   o_sym_stb        : one-cycle pulse in the first cycle of each symbol
//   o_underrun       : one-cycle pulse when the payload ran dry mid-frame
// ---------------------------------------------------------------------------
module qpsk_framer #(
   parameter int unsigned SPS           = 4,
   parameter int unsigned PREAMBLE_SYMS = 16,
   parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   input  logic       i_ready,
   output logic       o_I,
   output logic       o_Q,
   output logic       o_valid,
   output logic       o_sym_stb,
   output logic       o_underrun
);

   localparam int unsigned   CW       = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
   localparam logic [6:0]    PRE_LAST = 7'(PREAMBLE_SYMS - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_SYNC     = 2'd2,
      ST_PAYLOAD  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;          // sample index within the symbol
   logic [6:0]    sym_q, sym_d;          // symbol index within the phase
   logic [7:0]    hold_q, hold_d;
   logic          hold_last_q, hold_last_d;
   logic          hold_full_q, hold_full_d;
   logic [7:0]    shift_q, shift_d;      // byte being sent, next dibit in [7:6]
   logic          cur_last_q, cur_last_d;
   logic          underrun_q, underrun_d;

   logic          sym_end_s;
   logic [31:0]   sync_sh_s;
   logic          dib_i_s, dib_q_s;

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CW{1'b0}};
         sym_q       <= 7'd0;
         hold_q      <= 8'd0;
         hold_last_q <= 1'b0;
         hold_full_q <= 1'b0;
         shift_q     <= 8'd0;
         cur_last_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sym_q       <= sym_d;
         hold_q      <= hold_d;
         hold_last_q <= hold_last_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         cur_last_q  <= cur_last_d;
         underrun_q  <= underrun_d;
      end
   end

   // A symbol ends on its last sample, and only when the modulator takes it.
   assign sym_end_s = (state_q != ST_IDLE) && i_ready && (cnt_q == CNT_LAST);

   // Next-state logic: sample/symbol counters, phase sequencing, byte handoff.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sym_d       = sym_q;
      hold_d      = hold_q;
      hold_last_d = hold_last_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      cur_last_d  = cur_last_q;
      underrun_d  = 1'b0;

      // The holding register may fill even while the framer is stalled.
      if (s_valid && !hold_full_q) begin
         hold_d      = s_data;
         hold_last_d = s_last;
         hold_full_d = 1'b1;
      end else begin
         hold_d      = hold_q;
      end

      if ((state_q != ST_IDLE) && i_ready) begin
         cnt_d = (cnt_q == CNT_LAST) ? {CW{1'b0}} : (cnt_q + CW'(1));
      end else begin
         cnt_d = cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (hold_full_q && i_ready) begin
               state_d = ST_PREAMBLE;
               sym_d   = 7'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PREAMBLE: begin
            if (sym_end_s) begin
               if (sym_q == PRE_LAST) begin
                  state_d = ST_SYNC;
                  sym_d   = 7'd0;
               end else begin
                  sym_d   = sym_q + 7'd1;
               end
            end else begin
               sym_d = sym_q;
            end
         end
         ST_SYNC: begin
            if (sym_end_s) begin
               if (sym_q == 7'd15) begin
                  // The byte that launched the frame is still in hold here;
                  // s_ready stayed low all the way through preamble and sync.
                  state_d     = ST_PAYLOAD;
                  sym_d       = 7'd0;
                  shift_d     = hold_q;
                  cur_last_d  = hold_last_q;
                  hold_full_d = 1'b0;
               end else begin
                  sym_d       = sym_q + 7'd1;
               end
            end else begin
               sym_d = sym_q;
            end
         end
         ST_PAYLOAD: begin
            if (sym_end_s) begin
               if (sym_q == 7'd3) begin
                  sym_d = 7'd0;
                  if (cur_last_q) begin
                     state_d = ST_IDLE;
                  end else if (hold_full_q) begin
                     shift_d     = hold_q;
                     cur_last_d  = hold_last_q;
                     hold_full_d = 1'b0;
                  end else begin
                     underrun_d  = 1'b1;
                     state_d     = ST_IDLE;
                  end
               end else begin
                  sym_d   = sym_q + 7'd1;
                  shift_d = {shift_q[5:0], 2'b00};
               end
            end else begin
               sym_d = sym_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Dibit selection, decoded straight from the phase registers.
   always_comb begin
      sync_sh_s = SYNC_WORD << {sym_q[3:0], 1'b0};
      case (state_q)
         ST_IDLE: begin
            dib_i_s = 1'b0;
            dib_q_s = 1'b0;
         end
         ST_PREAMBLE: begin
            dib_i_s = sym_q[0];
            dib_q_s = sym_q[0];
         end
         ST_SYNC: begin
            dib_i_s = sync_sh_s[31];
            dib_q_s = sync_sh_s[30];
         end
         ST_PAYLOAD: begin
            dib_i_s = shift_q[7];
            dib_q_s = shift_q[6];
         end
         default: begin
            dib_i_s = 1'b0;
            dib_q_s = 1'b0;
         end
      endcase
   end

   assign s_ready    = !hold_full_q;
   assign o_valid    = (state_q != ST_IDLE);
   assign o_sym_stb  = (state_q != ST_IDLE) && (cnt_q == {CW{1'b0}}) && i_ready;
   assign o_underrun = underrun_q;
   assign o_I        = dib_i_s;
   assign o_Q        = dib_q_s;

endmodule

// File: tb/tb_qpsk_framer.sv
// ---------------------------------------------------------------------------
// tb_qpsk_framer
// Self-checking bench for qpsk_framer. Two instances share the stimulus:
// dut1 with default parameters and dut2 with SPS=2, PREAMBLE_SYMS=2; 'sel'
// picks which one the monitor observes. Expected dibit streams come from a
// frame-level model (preamble pattern, sync word, payload bytes).
// ---------------------------------------------------------------------------
module tb_qpsk_framer;

   localparam logic [31:0] SYNCW = 32'h1ACFFC1D;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid, s_last, i_ready;
   logic       s_ready1, o_i1, o_q1, o_valid1, o_stb1, o_und1;
   logic       s_ready2, o_i2, o_q2, o_valid2, o_stb2, o_und2;

   logic       sel;
   logic       mon_ready, mon_i, mon_q, mon_valid, mon_stb, mon_und;

   int         total = 0;
   int         bad   = 0;

   logic [7:0] tx_data [0:7];
   logic       tx_last [0:7];
   logic [1:0] exp_q[$];
   logic [1:0] cap_q[$];
   int         cap_valid, cap_stall, cap_stb, cap_gap_bad, cap_ready_low;
   logic       cap_und_after, cap_done;
   int         exp_sps;

   always #5 clk = ~clk;

   qpsk_framer dut1 (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready1), .i_ready(i_ready),
      .o_I(o_i1), .o_Q(o_q1), .o_valid(o_valid1), .o_sym_stb(o_stb1),
      .o_underrun(o_und1)
   );

   qpsk_framer #(.SPS(2), .PREAMBLE_SYMS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(s_ready2), .i_ready(i_ready),
      .o_I(o_i2), .o_Q(o_q2), .o_valid(o_valid2), .o_sym_stb(o_stb2),
      .o_underrun(o_und2)
   );

   assign mon_ready = sel ? s_ready2 : s_ready1;
   assign mon_i     = sel ? o_i2     : o_i1;
   assign mon_q     = sel ? o_q2     : o_q1;
   assign mon_valid = sel ? o_valid2 : o_valid1;
   assign mon_stb   = sel ? o_stb2   : o_stb1;
   assign mon_und   = sel ? o_und2   : o_und1;

   // Frame model: preamble, sync word, then bytes up to the first last=1.
   task automatic build_model(input int psyms, input int nbytes);
      logic [31:0] w;
      logic [7:0]  b;
      exp_q.delete();
      for (int i = 0; i < psyms; i++) exp_q.push_back((i % 2) ? 2'b11 : 2'b00);
      for (int i = 0; i < 16; i++) begin
         w = SYNCW >> (30 - 2 * i);
         exp_q.push_back(w[1:0]);
      end
      for (int k = 0; k < nbytes; k++) begin
         for (int j = 0; j < 4; j++) begin
            b = tx_data[k] >> (6 - 2 * j);
            exp_q.push_back(b[1:0]);
         end
         if (tx_last[k]) break;
      end
   endtask

   // Offer tx_data[0..n-1] with s_valid held high between bytes.
   task automatic feed(input int n);
      int w;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = tx_data[k];
         s_last  = tx_last[k];
         w = 0;
         while (!mon_ready && w < 2000) begin
            @(negedge clk);
            w++;
         end
         if (!mon_ready) begin
            total++; bad++;
            $display("FAIL feed_timeout byte=%0d waited=%0d limit=2000", k, w);
         end
         @(posedge clk);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Record one frame of the selected DUT, sampling on falling edges.
   task automatic capture(input int budget);
      int n;
      int last_stb;
      n = 0; last_stb = -1;
      cap_q.delete();
      cap_valid = 0; cap_stall = 0; cap_stb = 0; cap_gap_bad = 0; cap_ready_low = 0;
      @(negedge clk);
      while (!mon_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      while (mon_valid && n < budget) begin
         cap_valid++;
         if (!i_ready)   cap_stall++;
         if (!mon_ready) cap_ready_low++;
         if (mon_stb) begin
            cap_q.push_back({mon_i, mon_q});
            cap_stb++;
            if (last_stb >= 0 && (n - last_stb) != exp_sps) cap_gap_bad++;
            last_stb = n;
         end
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("FAIL capture_timeout cycles=%0d limit=%0d", n, budget);
      end
      cap_und_after = mon_und;
      cap_done      = 1'b1;
   endtask

   task automatic test_reset;
      sel = 1'b0; exp_sps = 4;
      rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; i_ready = 1'b1;
      #12;
      total++; if (o_valid1 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", o_valid1); end
      total++; if ({o_i1, o_q1} !== 2'b00) begin bad++; $display("FAIL rst_iq got=%b exp=00", {o_i1, o_q1}); end
      total++; if (o_stb1 !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b exp=0", o_stb1); end
      total++; if (o_und1 !== 1'b0) begin bad++; $display("FAIL rst_und got=%b exp=0", o_und1); end
      total++; if (s_ready1 !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", s_ready1); end
      total++; if (o_valid2 !== 1'b0) begin bad++; $display("FAIL rst_valid2 got=%b exp=0", o_valid2); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_byte;
      tx_data[0] = 8'hB4; tx_last[0] = 1'b1;
      build_model(16, 1);
      fork
         feed(1);
         capture(3000);
      join
      total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL single_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_sym%0d got=%b exp=%b", i, cap_q[i], exp_q[i]); end
      end
      total++; if (cap_valid !== 144) begin bad++; $display("FAIL single_valid_cycles got=%0d exp=144", cap_valid); end
      total++; if (cap_und_after !== 1'b0) begin bad++; $display("FAIL single_underrun got=%b exp=0", cap_und_after); end
   endtask

   task automatic test_stream;
      tx_data[0] = 8'h00; tx_last[0] = 1'b0;
      tx_data[1] = 8'hFF; tx_last[1] = 1'b1;
      build_model(16, 2);
      fork
         feed(2);
         capture(3000);
      join
      total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL stream_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL stream_sym%0d got=%b exp=%b", i, cap_q[i], exp_q[i]); end
      end
      total++; if (cap_valid !== 160) begin bad++; $display("FAIL stream_valid_cycles got=%0d exp=160", cap_valid); end
      // Low through preamble+sync (first byte held), high for the one cycle
      // after it moves out, then low until the first byte's last symbol ends.
      total++; if (cap_ready_low !== (32 * 4 + 4 * 4 - 1)) begin bad++; $display("FAIL stream_ready_low got=%0d exp=%0d", cap_ready_low, 32 * 4 + 4 * 4 - 1); end
   endtask

   task automatic test_stall;
      tx_data[0] = 8'($urandom_range(0, 255)); tx_last[0] = 1'b1;
      build_model(16, 1);
      fork
         feed(1);
         capture(3000);
         begin
            logic ri, rq;
            int   w;
            w = 0;
            while (!mon_valid && w < 100) begin
               @(negedge clk);
               w++;
            end
            repeat (74) @(posedge clk);
            #1;
            ri = mon_i; rq = mon_q;
            i_ready = 1'b0;
            for (int c = 0; c < 7; c++) begin
               @(negedge clk);
               total++; if ({mon_i, mon_q} !== {ri, rq}) begin bad++; $display("FAIL stall_iq c=%0d got=%b exp=%b", c, {mon_i, mon_q}, {ri, rq}); end
               total++; if (mon_stb !== 1'b0) begin bad++; $display("FAIL stall_stb c=%0d got=%b exp=0", c, mon_stb); end
               @(posedge clk);
            end
            #1;
            i_ready = 1'b1;
         end
      join
      total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL stall_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_sym%0d got=%b exp=%b", i, cap_q[i], exp_q[i]); end
      end
      total++; if (cap_valid !== 151) begin bad++; $display("FAIL stall_valid_cycles got=%0d exp=151", cap_valid); end
   endtask

   task automatic test_underrun;
      tx_data[0] = 8'($urandom_range(0, 255)); tx_last[0] = 1'b0;
      build_model(16, 1);
      fork
         feed(1);
         capture(3000);
      join
      total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL under_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL under_sym%0d got=%b exp=%b", i, cap_q[i], exp_q[i]); end
      end
      total++; if (cap_valid !== 144) begin bad++; $display("FAIL under_valid_cycles got=%0d exp=144", cap_valid); end
      total++; if (cap_und_after !== 1'b1) begin bad++; $display("FAIL under_pulse got=%b exp=1", cap_und_after); end
      @(negedge clk);
      total++; if (mon_und !== 1'b0) begin bad++; $display("FAIL under_pulse_width got=%b exp=0", mon_und); end
      total++; if (mon_valid !== 1'b0) begin bad++; $display("FAIL under_idle got=%b exp=0", mon_valid); end
   endtask

   task automatic test_reset_mid;
      tx_data[0] = 8'($urandom_range(0, 255)); tx_last[0] = 1'b0;
      tx_data[1] = 8'($urandom_range(0, 255)); tx_last[1] = 1'b1;
      feed(2);
      total++; if (mon_valid !== 1'b1) begin bad++; $display("FAIL rmid_inframe got=%b exp=1", mon_valid); end
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (mon_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", mon_valid); end
      total++; if ({mon_i, mon_q} !== 2'b00) begin bad++; $display("FAIL rmid_iq got=%b exp=00", {mon_i, mon_q}); end
      total++; if (mon_stb !== 1'b0) begin bad++; $display("FAIL rmid_stb got=%b exp=0", mon_stb); end
      total++; if (mon_und !== 1'b0) begin bad++; $display("FAIL rmid_und got=%b exp=0", mon_und); end
      total++; if (mon_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", mon_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      total++; if (mon_valid !== 1'b0) begin bad++; $display("FAIL rmid_hold_discarded got=%b exp=0", mon_valid); end
      tx_data[0] = 8'($urandom_range(0, 255)); tx_last[0] = 1'b1;
      build_model(16, 1);
      fork
         feed(1);
         capture(3000);
      join
      total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL rmid_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_sym%0d got=%b exp=%b", i, cap_q[i], exp_q[i]); end
      end
      total++; if (cap_valid !== 144) begin bad++; $display("FAIL rmid_valid_cycles got=%0d exp=144", cap_valid); end
   endtask

   task automatic test_random;
      int n;
      for (int f = 0; f < 3; f++) begin
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            tx_data[k] = 8'($urandom_range(0, 255));
            tx_last[k] = (k == n - 1);
         end
         build_model(16, n);
         cap_done = 1'b0;
         fork
            feed(n);
            capture(5000);
            begin
               while (!cap_done) begin
                  @(posedge clk);
                  #1;
                  i_ready = ($urandom_range(0, 3) != 0);
               end
               i_ready = 1'b1;
            end
         join
         total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand%0d_len got=%0d exp=%0d", f, cap_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_sym%0d got=%b exp=%b", f, i, cap_q[i], exp_q[i]); end
         end
         total++; if (cap_valid !== (32 + 4 * n) * 4 + cap_stall) begin bad++; $display("FAIL rand%0d_valid_cycles got=%0d exp=%0d", f, cap_valid, (32 + 4 * n) * 4 + cap_stall); end
      end
   endtask

   task automatic test_small_params;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sel = 1'b1; exp_sps = 2;
      tx_data[0] = 8'hA5; tx_last[0] = 1'b0;
      tx_data[1] = 8'h3C; tx_last[1] = 1'b1;
      build_model(2, 2);
      fork
         feed(2);
         capture(3000);
      join
      total++; if (cap_q.size() !== exp_q.size()) begin bad++; $display("FAIL small_len got=%0d exp=%0d", cap_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
         total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL small_sym%0d got=%b exp=%b", i, cap_q[i], exp_q[i]); end
      end
      total++; if (cap_valid !== 52) begin bad++; $display("FAIL small_valid_cycles got=%0d exp=52", cap_valid); end
      total++; if (cap_stb !== 26) begin bad++; $display("FAIL small_stb_count got=%0d exp=26", cap_stb); end
      total++; if (cap_gap_bad !== 0) begin bad++; $display("FAIL small_stb_spacing bad_gaps=%0d exp=0", cap_gap_bad); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_stream();
      test_stall();
      test_underrun();
      test_reset_mid();
      test_random();
      test_small_params();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
